// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands one round key per clock into an (NR+1)-entry
// register file, streams each key as it is produced and exposes a combinational read port.
module key_schedule_ctrl #(
  parameter int Nk = 4,
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [32*Nk-1:0]   key_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               keys_valid_o,
  output logic               rk_valid_o,
  output logic [3:0]         rk_idx_o,
  output logic [32*Nk-1:0]   rk_data_o,
  input  logic [3:0]         rd_addr_i,
  output logic [32*Nk-1:0]   rd_key_o
);
  localparam int         KW   = 32 * Nk;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic {IDLE, EXPAND} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as x^254 (the GF(2^8) inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [KW-1:0] key_expand(input logic [KW-1:0] k, input logic [7:0] rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0  = k[127:96] ^ t;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [7:0]      rc_q, rc_d;
  logic            busy_q, busy_d, done_q, done_d, kv_q, kv_d, rkv_q, rkv_d;
  logic [3:0]      idx_q, idx_d;
  logic [KW-1:0]   data_q, data_d;
  logic [KW-1:0]   file_q [0:NR];
  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [KW-1:0]   wr_data, next_key;

  // The streamed key register always holds the previous round key while expanding.
  assign next_key = key_expand(data_q, rc_q);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rc_d    = rc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    rkv_d   = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_en   = 1'b0;
    wr_idx  = round_q;
    wr_data = next_key;
    unique case (state_q)
      IDLE: if (start_i) begin
        wr_en   = 1'b1;
        wr_idx  = 4'd0;
        wr_data = key_in_i;
        rkv_d   = 1'b1;
        idx_d   = 4'd0;
        data_d  = key_in_i;
        kv_d    = 1'b0;
        busy_d  = 1'b1;
        round_d = 4'd1;
        rc_d    = 8'h01;
        state_d = EXPAND;
      end
      EXPAND: begin
        wr_en   = 1'b1;
        rkv_d   = 1'b1;
        idx_d   = round_q;
        data_d  = next_key;
        rc_d    = xtime(rc_q);
        round_d = round_q + 4'd1;
        if (round_q == NR_L) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rc_q    <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      rkv_q   <= 1'b0;
      idx_q   <= 4'd0;
      data_q  <= '0;
      for (int i = 0; i <= NR; i++) file_q[i] <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rc_q    <= rc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      rkv_q   <= rkv_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      if (wr_en) file_q[wr_idx] <= wr_data;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = kv_q;
  assign rk_valid_o   = rkv_q;
  assign rk_idx_o     = idx_q;
  assign rk_data_o    = data_q;
  assign rd_key_o     = (rd_addr_i <= NR_L) ? file_q[rd_addr_i] : '0;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Randomized bench for key_schedule_ctrl against a word-oriented FIPS-197 key expansion model.
module tb_key_schedule_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid, rk_valid;
  logic [3:0]   rk_idx, rd_addr;
  logic [127:0] rk_data, rd_key;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] mdl [0:10];
  logic [7:0]   rcon [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  key_schedule_ctrl #(.Nk(4), .NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .key_in_i(key_in),
    .busy_o(busy), .done_o(done), .keys_valid_o(keys_valid), .rk_valid_o(rk_valid),
    .rk_idx_o(rk_idx), .rk_data_o(rk_data), .rd_addr_i(rd_addr), .rd_key_o(rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int acc, x;
    acc = 0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  // S-box table: brute-force multiplicative inverse, then the bitwise affine formula.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
      sb[x] = s;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full expansion; optionally pulses a stray start (key 0) sampled at edge T+3.
  task automatic run_exp(input logic [127:0] key, input bit inject);
    model(key);
    key_in = key;
    start  = 1'b1;
    step();
    start  = 1'b0;
    key_in = rnd128();
    chk("t0_rkv", 128'(rk_valid), 128'd1);
    chk("t0_idx", 128'(rk_idx), 128'd0);
    chk("t0_data", rk_data, mdl[0]);
    chk("t0_busy", 128'(busy), 128'd1);
    chk("t0_kv", 128'(keys_valid), 128'd0);
    for (int k = 1; k <= 10; k++) begin
      if (inject && k == 3) begin
        start  = 1'b1;
        key_in = '0;
      end
      step();
      start = 1'b0;
      chk($sformatf("r%0d_rkv", k), 128'(rk_valid), 128'd1);
      chk($sformatf("r%0d_idx", k), 128'(rk_idx), 128'(k));
      chk($sformatf("r%0d_data", k), rk_data, mdl[k]);
      chk($sformatf("r%0d_done", k), 128'(done), 128'(k == 10));
      chk($sformatf("r%0d_busy", k), 128'(busy), 128'(k != 10));
      chk($sformatf("r%0d_kv", k), 128'(keys_valid), 128'(k == 10));
    end
    step();
    chk("post_rkv", 128'(rk_valid), 128'd0);
    chk("post_done", 128'(done), 128'd0);
    chk("post_kv", 128'(keys_valid), 128'd1);
    chk("post_busy", 128'(busy), 128'd0);
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("rd%0d", a), rd_key, (a <= 10) ? mdl[a] : 128'h0);
    end
  endtask

  initial begin
    logic [127:0] kb [0:2];
    int e, ph;
    build_sbox();
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_addr = 4'd0;
    #3;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_rkv", 128'(rk_valid), 128'd0);
    chk("rst_idx", 128'(rk_idx), 128'd0);
    chk("rst_data", rk_data, 128'h0);
    chk("rst_rd0", rd_key, 128'h0);
    step();
    rst_n = 1'b1;
    step();

    // FIPS-197 vector, then the same with a stray start mid-expansion
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rd_addr = 4'd1;  #1; chk("fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_addr = 4'd10; #1; chk("fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep();
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    sweep();

    run_exp(128'h0, 1'b0);
    rd_addr = 4'd1;  #1; chk("zero_rk1", rd_key, 128'h62636363626363636263636362636363);
    rd_addr = 4'd10; #1; chk("zero_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int n = 0; n < 4; n++) begin
      run_exp(rnd128(), n[0]);
      sweep();
    end

    // Reset during round 5
    key_in = rnd128();
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_rkv", 128'(rk_valid), 128'd0);
    chk("mid_idx", 128'(rk_idx), 128'd0);
    chk("mid_data", rk_data, 128'h0);
    chk("mid_kv", 128'(keys_valid), 128'd0);
    rd_addr = 4'd0; #1; chk("mid_rd0", rd_key, 128'h0);
    step();
    rst_n = 1'b1;
    step();
    run_exp(rnd128(), 1'b0);
    sweep();

    // Start held high: back-to-back expansions
    for (int i = 0; i < 3; i++) kb[i] = rnd128();
    key_in = kb[0];
    start  = 1'b1;
    for (int j = 0; j < 33; j++) begin
      e  = j / 11;
      ph = j % 11;
      if (ph == 0) model(kb[e]);
      step();
      chk($sformatf("b2b%0d_rkv", j), 128'(rk_valid), 128'd1);
      chk($sformatf("b2b%0d_idx", j), 128'(rk_idx), 128'(ph));
      chk($sformatf("b2b%0d_data", j), rk_data, mdl[ph]);
      chk($sformatf("b2b%0d_kv", j), 128'(keys_valid), 128'(ph == 10));
      chk($sformatf("b2b%0d_done", j), 128'(done), 128'(ph == 10));
      if (ph == 1) key_in = rnd128();
      if (ph == 10 && e < 2) key_in = kb[e+1];
    end
    start = 1'b0;
    step();
    chk("b2b_end_rkv", 128'(rk_valid), 128'd0);
    chk("b2b_end_kv", 128'(keys_valid), 128'd1);
    sweep();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
